// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D memory port arbiter; MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-break
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  input  logic                    i_ren,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_rvalid,
  input  logic [ADDR_WIDTH-1:0]   d_raddr,
  input  logic                    d_ren,
  input  logic [ADDR_WIDTH-1:0]   d_waddr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_rvalid,
  output logic                    d_wvalid,
  output logic [ADDR_WIDTH-1:0]   m_raddr,
  output logic                    m_ren,
  output logic [ADDR_WIDTH-1:0]   m_waddr,
  output logic                    m_wen,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wmask,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_rvalid,
  input  logic                    m_wvalid,
  output logic                    busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  logic [1:0] state_q, state_d;
  logic       rd_done_q, rd_done_d;
  logic       wr_done_q, wr_done_d;
  logic       gnt_i, gnt_d, d_req, pick_d;

  // Grants are masked by rstn so the port is released in the reset cycle itself.
  assign gnt_i = rstn && (state_q == ST_GRANT_I);
  assign gnt_d = rstn && (state_q == ST_GRANT_D);
  assign d_req = d_ren | d_wen;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  assign pick_d = d_req & (~i_ren | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if ((state_q == ST_IDLE) && (d_req | i_ren)) begin
      last_d_d = pick_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  assign m_ren   = gnt_i ? (i_ren & ~rd_done_q) :
                   gnt_d ? (d_ren & ~rd_done_q) : 1'b0;
  assign m_wen   = gnt_d & d_wen & ~wr_done_q;
  assign m_raddr = gnt_i ? i_raddr : (gnt_d ? d_raddr : '0);
  assign m_waddr = gnt_d ? d_waddr : '0;
  assign m_wdata = gnt_d ? d_wdata : '0;
  assign m_wmask = gnt_d ? d_wmask : '0;

  // An ack only counts while the matching enable is still driven; strays are dropped.
  assign i_rvalid = gnt_i & m_rvalid & m_ren;
  assign d_rvalid = gnt_d & m_rvalid & m_ren;
  assign d_wvalid = gnt_d & m_wvalid & m_wen;
  assign i_rdata  = gnt_i ? m_rdata : '0;
  assign d_rdata  = gnt_d ? m_rdata : '0;
  assign busy     = gnt_i | gnt_d;

  always_comb begin
    state_d   = state_q;
    rd_done_d = rd_done_q | (m_rvalid & m_ren);
    wr_done_d = wr_done_q | (m_wvalid & m_wen);
    case (state_q)
      ST_IDLE: begin
        if (d_req | i_ren) begin
          state_d = pick_d ? ST_GRANT_D : ST_GRANT_I;
        end
      end
      ST_GRANT_I: begin
        if (rd_done_q | ~i_ren) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_D: begin
        if ((rd_done_q | ~d_ren) & (wr_done_q | ~d_wen)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      rd_done_d = 1'b0;
      wr_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-side and data-side cache wrappers.
- Each requester presents the flat equivalent of the team's Mem_ift master signals (read addr/ren, write addr/wen/wdata/wmask) and receives rdata/rvalid/wvalid.
- Grants one requester at a time and holds the grant until its transaction completes.
- Sits between the I/D cache wrappers and the memory/bus bridge.

Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 128, memory-port data width (two CPU words per beat).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- i_raddr  in  ADDR_WIDTH  instruction-side read address.
- i_ren  in  1  instruction-side read request, held until i_rvalid.
- i_rdata  out  DATA_WIDTH  instruction-side read data.
- i_rvalid  out  1  instruction-side read done, 1-cycle pulse.
- d_raddr  in  ADDR_WIDTH  data-side read address.
- d_ren  in  1  data-side read request.
- d_waddr  in  ADDR_WIDTH  data-side write address.
- d_wen  in  1  data-side write request.
- d_wdata  in  DATA_WIDTH  data-side write data.
- d_wmask  in  DATA_WIDTH/8  data-side byte mask.
- d_rdata  out  DATA_WIDTH  data-side read data.
- d_rvalid  out  1  data-side read done pulse.
- d_wvalid  out  1  data-side write done pulse.
- m_raddr  out  ADDR_WIDTH  memory read address.
- m_ren  out  1  memory read enable.
- m_waddr  out  ADDR_WIDTH  memory write address.
- m_wen  out  1  memory write enable.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_wmask  out  DATA_WIDTH/8  memory byte mask.
- m_rdata  in  DATA_WIDTH  memory read data.
- m_rvalid  in  1  memory read done pulse.
- m_wvalid  in  1  memory write done pulse.
- busy  out  1  a grant is active.

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D. State is registered; reset → IDLE.
- Reset values: all m_* enables 0, all addr/data/mask outputs 0, all valid outputs 0, busy 0, done flags 0, last-grant = I.
- Reset mid-transaction: return to IDLE immediately and drop m_ren/m_wen. Memory acks arriving afterwards are ignored.
- IDLE:
  - No m_ren/m_wen driven; m_* address/data outputs are 0.
  - Any request samples arbitration at the clock edge → GRANT_I or GRANT_D next cycle.
  - Grant latency is 1 cycle: m_* is first driven in the cycle after the request is first seen.
- Arbitration (macro off): fixed priority, data side wins when i_ren and (d_ren|d_wen) rise in the same cycle.
- GRANT_I:
  - m_raddr = i_raddr; m_ren = i_ren & ~rd_done; m_wen = 0.
- GRANT_D:
  - m_raddr/m_waddr/m_wdata/m_wmask forwarded combinationally from the d_* inputs.
  - m_ren = d_ren & ~rd_done; m_wen = d_wen & ~wr_done.
  - Read and write may be outstanding together.
- Done flags:
  - rd_done sets on m_rvalid while m_ren is high; wr_done sets on m_wvalid while m_wen is high.
  - Both flags clear on leaving a GRANT state.
- Ack routing:
  - m_rvalid/m_rdata go only to the granted side; the ungranted side sees valid 0 and rdata 0.
  - A valid pulse that arrives with no matching enable is dropped.
- Completion:
  - Leave the grant (→ IDLE) when every enable the grantee asserted is acked, or the grantee drops all of its enables.
  - Completion is checked the cycle after the last ack, since the requester samples the valid pulse and deasserts.
  - Minimum 1 IDLE cycle between grants; no back-to-back grants.
- Starvation: the losing requester keeps its request high and is granted after the current transaction ends.
- busy = (state != IDLE).

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- When defined: on a simultaneous I and D request, grant the side not granted last; last-grant updates on every grant.
- When undefined: fixed D-over-I priority as above; last-grant register not implemented.

Test Plan:
- I-only read: i_raddr=0x8000_0000, i_ren=1; memory returns rvalid 3 cycles after m_ren with rdata=0x1234… → m_ren rises 1 cycle after i_ren, i_rvalid pulses with that data, d_rvalid stays 0, state returns to IDLE.
- Simultaneous i_ren and d_ren at cycle 0:
  - Macro off: D granted first, I granted after the D ack plus 1 IDLE cycle.
  - Macro on with last-grant = D: I granted first.
- D write + read together: d_wen=1 (waddr 0x100, wmask 0xFFFF) and d_ren=1 (raddr 0x200); m_wvalid at +2, m_rvalid at +5 → m_wen drops after +2, m_ren stays high until +5, single grant throughout, d_wvalid and d_rvalid each pulse once.
- Mid-grant request: d_wen rises while I is granted → m_wen stays 0 until I completes; D granted afterwards; i_rdata unaffected.
- Spurious ack: m_rvalid=1 in IDLE → no valid pulse on either side, state stays IDLE.
- Reset during GRANT_D with m_ren high: rstn=0 for 1 cycle → next cycle m_ren=0, busy=0, state IDLE; a late m_rvalid is ignored.
